arbiter: RTL and testbench
==========================

// Module: arbiter
// PURPOSE
//   Two-requester fixed-priority grant arbiter for shared LightIO resources.
//   A priority requester and a normal requester compete for one resource.
//   Grants are registered, mutually exclusive and issued one clock after the request is sampled.
//   A starvation guard guarantees forward progress for the normal requester.
// PARAMETERS
//   STARVE_LIMIT  4  consecutive priority grants, with normal waiting, before normal is forced one slot; 0 = guard disabled
// PORTS
//   clock         in   1  single system clock; all state on rising edge
//   reset         in   1  synchronous, active-low reset (sampled on rising clock edge)
//   in_priority   in   1  request from high-priority client; level, held while service wanted
//   in_normal     in   1  request from normal client; level, held while service wanted
//   out_priority  out  1  grant to priority client (registered)
//   out_normal    out  1  grant to normal client (registered)
// BEHAVIOUR
//   - One clock, one synchronous active-low reset; no other asynchronous paths.
//   - Reset (reset==0 at edge):
//     - out_priority=0, out_normal=0.
//     - FSM goes to IDLE.
//     - Starvation counter = 0.
//   - Invariant: out_priority & out_normal == 0 on every cycle.
//   - Latency: requests sampled at edge N drive grants visible after edge N; 1-cycle request->grant.
//     - Dropping a request drops its grant at the next edge.
//   - FSM states IDLE, GRANT_PRI, GRANT_NORM, FORCE_NORM; outputs decoded from state.
//     - GRANT_PRI -> out_priority=1.
//     - GRANT_NORM/FORCE_NORM -> out_normal=1.
//     - IDLE -> both 0.
//   - Next state, evaluated in order:
//     1. Guard fires: STARVE_LIMIT>0, state==GRANT_PRI, in_normal=1 and counter==STARVE_LIMIT-1
//        -> FORCE_NORM, counter cleared.
//     2. state==FORCE_NORM
//        -> GRANT_PRI if in_priority, else GRANT_NORM if in_normal, else IDLE.
//        - FORCE_NORM lasts exactly one cycle.
//     3. in_priority=1 -> GRANT_PRI.
//        - This preempts an ongoing normal grant: out_normal falls and out_priority rises on the same edge.
//     4. in_normal=1 -> GRANT_NORM.
//     5. else -> IDLE.
//   - Starvation counter (width $clog2(STARVE_LIMIT+1), min 1):
//     - Increments each edge where state==GRANT_PRI and in_normal=1.
//     - Clears when in_normal=0, when the state leaves GRANT_PRI, or on reset.
//     - Saturates; never wraps.
//   - Simultaneous in_priority=1, in_normal=1 from IDLE: grant priority.
//     - Normal wins only via the guard.
//   - Both requests withdrawn: IDLE on next edge, no grant held.
//   - Reset asserted mid-grant: grants drop at that edge regardless of inputs.
//     - First grant possible one edge after reset deasserts.
//   - Inputs are assumed synchronous to clock; no internal synchronizers.
// STRUCTURE
//   - Shared package (arbiter_pkg):
//     - FSM state typedef/localparams: IDLE=2'd0, GRANT_PRI=2'd1, GRANT_NORM=2'd2, FORCE_NORM=2'd3.
//     - Default STARVE_LIMIT constant.
//   - Single flat module: state register, next-state logic, saturating counter, output decode.
//   - Natural optional sub-module: arbiter_starve_cnt (saturating counter with clear/enable, terminal flag).
// TESTING
//   1. reset=0 for 2 edges with in_priority=1, in_normal=1
//      -> out_priority=0, out_normal=0 throughout reset.
//   2. After reset: in_priority=1, in_normal=0 for 3 cycles
//      -> out_priority=1 from the next edge, out_normal=0.
//      - Release -> both 0 one edge later.
//   3. in_priority=0, in_normal=1 for 3 cycles
//      -> out_normal=1 after one edge.
//      - Then raise in_priority -> next edge out_priority=1, out_normal=0 (preemption).
//   4. in_priority=1, in_normal=1 held, STARVE_LIMIT=4
//      -> grants repeat: 4 cycles out_priority=1, then 1 cycle out_normal=1.
//      - Never both 1.
//   5. STARVE_LIMIT=0, both held 20 cycles -> out_priority=1 every cycle, out_normal=0.
//   6. Assert reset=0 during GRANT_NORM -> both outputs 0 at that edge.
//      - Deassert with in_normal=1 -> out_normal=1 one edge later.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the two-requester grant arbiter.
// State encoding is fixed so grant decode and debug views agree across tools.
package arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_PRI  = 2'd1,
        GRANT_NORM = 2'd2,
        FORCE_NORM = 2'd3
    } arb_state_t;

    // Consecutive priority grants tolerated while normal waits; 0 disables the guard.
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    function automatic int unsigned starve_cnt_width(input int unsigned limit);
        int unsigned w;
        w = (limit == 0) ? 1 : $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/arbiter_starve_cnt.sv
// Saturating up-counter with synchronous clear/enable and a terminal-count flag.
// Latency: flag reflects the registered count, valid the cycle after the update edge.
// Backpressure: none; clear wins over enable, count holds at all-ones instead of wrapping.
module arbiter_starve_cnt #(
    parameter int unsigned W    = 3,
    parameter logic [W-1:0] TERM = '0
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = (cnt == TERM);

endmodule

// File: rtl/arbiter.sv
// Two-requester fixed-priority arbiter with a starvation guard for the normal client.
// Latency: one edge from sampled request to registered grant; dropped requests lose grant next edge.
// Backpressure: level requests held by clients; priority wins unless normal has waited STARVE_LIMIT grants.
module arbiter
    import arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic in_priority,
    input  logic in_normal,
    output logic out_priority,
    output logic out_normal
);

    localparam int unsigned    CNT_W    = starve_cnt_width(STARVE_LIMIT);
    localparam bit             GUARD_EN = (STARVE_LIMIT > 0);
    localparam logic [CNT_W-1:0] TERM   = GUARD_EN ? CNT_W'(STARVE_LIMIT - 1) : '0;

    arb_state_t state;
    arb_state_t next_state;
    logic       cnt_term;
    logic       cnt_clr;
    logic       cnt_en;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        if (GUARD_EN && (state == GRANT_PRI) && in_normal && cnt_term) begin
            next_state = FORCE_NORM;
        end else if (state == FORCE_NORM) begin
            if (in_priority) begin
                next_state = GRANT_PRI;
            end else if (in_normal) begin
                next_state = GRANT_NORM;
            end else begin
                next_state = IDLE;
            end
        end else if (in_priority) begin
            next_state = GRANT_PRI;
        end else if (in_normal) begin
            next_state = GRANT_NORM;
        end else begin
            next_state = IDLE;
        end
    end

    // Count only priority grants that happen while normal is waiting; any break in that streak restarts it.
    assign cnt_en  = (state == GRANT_PRI) && in_normal;
    assign cnt_clr = !in_normal || (state != GRANT_PRI) || (next_state != GRANT_PRI);

    arbiter_starve_cnt #(
        .W    (CNT_W),
        .TERM (TERM)
    ) u_starve_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .term  (cnt_term)
    );

    assign out_priority = (state == GRANT_PRI);
    assign out_normal   = (state == GRANT_NORM) || (state == FORCE_NORM);

endmodule

// File: tb/tb_arbiter.sv
module tb_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic in_priority = 1'b0;
    logic in_normal = 1'b0;
    logic out_priority, out_normal;
    logic out_priority0, out_normal0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    arbiter #(.STARVE_LIMIT(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_priority  (in_priority),
        .in_normal    (in_normal),
        .out_priority (out_priority),
        .out_normal   (out_normal)
    );

    arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .in_priority  (in_priority),
        .in_normal    (in_normal),
        .out_priority (out_priority0),
        .out_normal   (out_normal0)
    );

    typedef struct {
        logic rst;
        logic p;
        logic n;
        logic exp_p;
        logic exp_n;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic p, input logic n,
                       input logic exp_p, input logic exp_n);
        vec_t v;
        v.rst = rst; v.p = p; v.n = n; v.exp_p = exp_p; v.exp_n = exp_n;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then sample 1ns later.
    task automatic step(input logic rst, input logic p, input logic n);
        reset = rst;
        in_priority = p;
        in_normal = n;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset held with both requests
        add(0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 0);
        // priority alone, then release
        add(1, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0);
        add(1, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0);
        // normal alone, then preempted by priority
        add(1, 0, 1, 0, 1);
        add(1, 0, 1, 0, 1);
        add(1, 0, 1, 0, 1);
        add(1, 1, 1, 1, 0);
        // both held: 4 priority, 1 forced normal, repeat
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 0, 1);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 0, 1);
        add(1, 1, 1, 1, 0);
        // normal grant, reset mid-grant, normal again one edge after release
        add(1, 0, 1, 0, 1);
        add(1, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0);
        add(1, 0, 1, 0, 1);
        add(1, 0, 0, 0, 0);
        // a gap in the normal request restarts the starvation streak
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 0, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 0);
        add(1, 1, 1, 0, 1);
        add(1, 0, 0, 0, 0);

        repeat (2) @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].p, vecs[i].n);
            check($sformatf("vec%0d out_priority", i), out_priority, vecs[i].exp_p);
            check($sformatf("vec%0d out_normal", i), out_normal, vecs[i].exp_n);
        end

        // Both held for 20 cycles after a fresh reset; guard-disabled instance never yields.
        step(0, 0, 0);
        check("rst out_priority0", out_priority0, 1'b0);
        check("rst out_normal0", out_normal0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step(1, 1, 1);
            check($sformatf("nolimit c%0d out_priority", k), out_priority0, 1'b1);
            check($sformatf("nolimit c%0d out_normal", k), out_normal0, 1'b0);
            check($sformatf("limit4 c%0d out_priority", k), out_priority, (k % 5) != 0);
            check($sformatf("limit4 c%0d out_normal", k), out_normal, (k % 5) == 0);
            check($sformatf("limit4 c%0d exclusive", k), out_priority & out_normal, 1'b0);
        end

        // Release both: idle on the next edge.
        step(1, 0, 0);
        check("release out_priority", out_priority, 1'b0);
        check("release out_normal", out_normal, 1'b0);
        check("release out_priority0", out_priority0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
